// File: rtl/mic_level_meter.sv
// -----------------------------------------------------------------------------
// mic_level_meter
//   Converts raw 12-bit microphone samples into a 4-bit volume level (0..15)
//   for the volume bar renderer. The peak sample is tracked over a fixed
//   window of WINDOW_SAMPLES valid strobes and quantised once per window.
//
// Parameters
//   WINDOW_SAMPLES : valid samples per window (2..65535)
//   BASELINE       : idle (zero-signal) code; samples at or below are silence
//   SHIFT          : right shift applied to (peak - BASELINE) to form the level
//
// Ports
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   mic_in      in  12   raw unsigned microphone sample
//   mic_valid   in   1   one-cycle strobe: mic_in holds a new sample
//   freeze      in   1   1 = hold level/peak_out, suppress level_valid
//   level       out  4   quantised volume (feeds volume bar mic_data)
//   peak_out    out 12   peak sample of the last completed window
//   level_valid out  1   one-cycle pulse when level/peak_out update
//
// Configuration macro
//   PEAK_DECAY_EN : when defined, level rises immediately but falls by at most
//                   one step per window (peak-hold ballistics). peak_out and
//                   level_valid are unaffected.
// -----------------------------------------------------------------------------
module mic_level_meter #(
   parameter int WINDOW_SAMPLES = 4000,
   parameter int BASELINE       = 2048,
   parameter int SHIFT          = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] mic_in,
   input  logic        mic_valid,
   input  logic        freeze,
   output logic [3:0]  level,
   output logic [11:0] peak_out,
   output logic        level_valid
);

   localparam int          CNT_W    = $clog2(WINDOW_SAMPLES);
   localparam logic [11:0] BASE12   = 12'(BASELINE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW_SAMPLES - 1);

   // Map a window peak to a 0..15 level. The subtraction only happens above
   // the baseline so the 12-bit difference can never wrap.
   function automatic logic [3:0] quantise(input logic [11:0] pk);
      logic [11:0] diff;
      logic [11:0] shifted;
      if (pk <= BASE12) begin
         quantise = 4'd0;
      end else begin
         diff    = pk - BASE12;
         shifted = diff >> SHIFT;
         if (shifted > 12'd15) begin
            quantise = 4'd15;
         end else begin
            quantise = shifted[3:0];
         end
      end
   endfunction

   logic [CNT_W-1:0] cnt_r;
   logic [11:0]      peak_r;
   logic [11:0]      pk_s;
   logic             win_end_s;
   logic [3:0]       q_s;
   logic [3:0]       level_next_s;

   // Running max including the current sample, so the final strobe of a
   // window is part of the value that gets quantised.
   always_comb begin
      pk_s         = peak_r;
      win_end_s    = 1'b0;
      q_s          = 4'd0;
      level_next_s = level;
      if (mic_in > peak_r) begin
         pk_s = mic_in;
      end else begin
         pk_s = peak_r;
      end
      win_end_s = mic_valid && (cnt_r == CNT_LAST);
      q_s       = quantise(pk_s);
`ifdef PEAK_DECAY_EN
      // Rise instantly, fall one step per window. q >= 0 always holds, so
      // the decrement branch is never taken with level at zero.
      if (q_s >= level) begin
         level_next_s = q_s;
      end else begin
         level_next_s = level - 4'd1;
      end
`else
      level_next_s = q_s;
`endif
   end

   // Window counter, peak tracker and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= '0;
         peak_r      <= 12'd0;
         level       <= 4'd0;
         peak_out    <= 12'd0;
         level_valid <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         if (mic_valid) begin
            if (win_end_s) begin
               // Clear for the next window; a sample cannot share this edge.
               cnt_r  <= '0;
               peak_r <= 12'd0;
               // A window completing under freeze is simply discarded.
               if (!freeze) begin
                  level       <= level_next_s;
                  peak_out    <= pk_s;
                  level_valid <= 1'b1;
               end
            end else begin
               cnt_r  <= cnt_r + CNT_W'(1);
               peak_r <= pk_s;
            end
         end
      end
   end

endmodule

// File: tb/tb_mic_level_meter.sv
// -----------------------------------------------------------------------------
// tb_mic_level_meter
//   Directed bench for mic_level_meter with WINDOW_SAMPLES=8, BASELINE=2048,
//   SHIFT=7. Expected values are hand-computed from the quantiser formula.
// -----------------------------------------------------------------------------
module tb_mic_level_meter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] mic_in = 12'd0;
   logic        mic_valid = 1'b0;
   logic        freeze = 1'b0;
   logic [3:0]  level;
   logic [11:0] peak_out;
   logic        level_valid;

   int checks = 0;
   int errors = 0;
   int pulse_cnt = 0;

   // Values captured by run_window
   logic        lv_end;
   logic        lv_after;
   logic [3:0]  lvl_end;
   logic [11:0] pk_end;

   mic_level_meter #(
      .WINDOW_SAMPLES(8),
      .BASELINE(2048),
      .SHIFT(7)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mic_in(mic_in),
      .mic_valid(mic_valid),
      .freeze(freeze),
      .level(level),
      .peak_out(peak_out),
      .level_valid(level_valid)
   );

   always #5 clk = ~clk;

   // Count every cycle in which level_valid is high.
   always @(posedge clk) begin
      if (level_valid) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      mic_valid = 1'b0;
      freeze = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // One full window: sample `pos` carries pk, the rest are 2048. `gap` idle
   // cycles follow every strobe. Outputs are captured right after the 8th.
   task automatic run_window(input logic [11:0] pk, input int pos, input int gap);
      for (int i = 0; i < 8; i++) begin
         mic_in = (i == pos) ? pk : 12'd2048;
         mic_valid = 1'b1;
         @(posedge clk); #1;
         mic_valid = 1'b0;
         if (i == 7) begin
            lv_end  = level_valid;
            lvl_end = level;
            pk_end  = peak_out;
         end
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      lv_after = level_valid;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
      checks++; if (peak_out !== 12'd0) begin errors++; $display("FAIL reset_peak got %0d exp 0", peak_out); end
      checks++; if (level_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", level_valid); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      // T1: five loud samples, then async reset mid-window
      for (int i = 0; i < 5; i++) begin
         mic_in = 12'd4095; mic_valid = 1'b1;
         @(posedge clk); #1;
      end
      mic_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (level_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL midreset_out got lv=%0b lvl=%0d exp 0 0", level_valid, level); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      begin
         int p0;
         p0 = pulse_cnt;
         run_window(12'd2048, 0, 0);
         checks++; if (lv_end !== 1'b1) begin errors++; $display("FAIL t1_valid got %0b exp 1", lv_end); end
         checks++; if (lvl_end !== 4'd0) begin errors++; $display("FAIL t1_level got %0d exp 0", lvl_end); end
         checks++; if (pk_end !== 12'd2048) begin errors++; $display("FAIL t1_peak got %0d exp 2048", pk_end); end
         checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL t1_pulses got %0d exp 1", pulse_cnt - p0); end
      end
   endtask

   task automatic test_quantise();
      logic [11:0] peaks [4];
      logic [3:0]  exps  [4];
      peaks = '{12'd2175, 12'd2176, 12'd3000, 12'd4095};
      exps  = '{4'd0, 4'd1, 4'd7, 4'd15};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         run_window(peaks[k], k + 1, 0);
         checks++; if (lv_end !== 1'b1) begin errors++; $display("FAIL t2_valid[%0d] got %0b exp 1", k, lv_end); end
         checks++; if (lvl_end !== exps[k]) begin errors++; $display("FAIL t2_level[%0d] got %0d exp %0d", k, lvl_end, exps[k]); end
         checks++; if (pk_end !== peaks[k]) begin errors++; $display("FAIL t2_peak[%0d] got %0d exp %0d", k, pk_end, peaks[k]); end
         checks++; if (lv_after !== 1'b0) begin errors++; $display("FAIL t2_pulse_width[%0d] got %0b exp 0", k, lv_after); end
      end
   endtask

   task automatic test_last_sample();
      do_reset();
      run_window(12'd4095, 7, 0);
      checks++; if (lvl_end !== 4'd15) begin errors++; $display("FAIL t3_level got %0d exp 15", lvl_end); end
      checks++; if (pk_end !== 12'd4095) begin errors++; $display("FAIL t3_peak got %0d exp 4095", pk_end); end
      checks++; if (lv_end !== 1'b1) begin errors++; $display("FAIL t3_valid got %0b exp 1", lv_end); end
   endtask

   task automatic test_back_to_back();
      int p0;
      logic [3:0] exp2;
`ifdef PEAK_DECAY_EN
      exp2 = 4'd3;
`else
      exp2 = 4'd1;
`endif
      do_reset();
      p0 = pulse_cnt;
      run_window(12'd2600, 3, 2);
      checks++; if (lvl_end !== 4'd4 || lv_end !== 1'b1) begin errors++; $display("FAIL t4_win1 got lvl=%0d lv=%0b exp 4 1", lvl_end, lv_end); end
      run_window(12'd2300, 5, 0);
      checks++; if (lvl_end !== exp2 || pk_end !== 12'd2300) begin errors++; $display("FAIL t4_win2 got lvl=%0d pk=%0d exp %0d 2300", lvl_end, pk_end, exp2); end
      checks++; if (pulse_cnt - p0 !== 2) begin errors++; $display("FAIL t4_pulses got %0d exp 2", pulse_cnt - p0); end
   endtask

   task automatic test_freeze();
      int p0;
      do_reset();
      run_window(12'd2300, 2, 0);
      checks++; if (lvl_end !== 4'd1) begin errors++; $display("FAIL t5_prior got %0d exp 1", lvl_end); end
      freeze = 1'b1;
      p0 = pulse_cnt;
      run_window(12'd4095, 4, 0);
      checks++; if (lv_end !== 1'b0) begin errors++; $display("FAIL t5_frozen_valid got %0b exp 0", lv_end); end
      checks++; if (lvl_end !== 4'd1 || pk_end !== 12'd2300) begin errors++; $display("FAIL t5_frozen_hold got lvl=%0d pk=%0d exp 1 2300", lvl_end, pk_end); end
      checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL t5_frozen_pulses got %0d exp 0", pulse_cnt - p0); end
      freeze = 1'b0;
      run_window(12'd2560, 6, 0);
      checks++; if (lvl_end !== 4'd4 || pk_end !== 12'd2560 || lv_end !== 1'b1) begin errors++; $display("FAIL t5_release got lvl=%0d pk=%0d lv=%0b exp 4 2560 1", lvl_end, pk_end, lv_end); end
   endtask

   task automatic test_decay();
      logic [3:0] exps [4];
`ifdef PEAK_DECAY_EN
      exps = '{4'd15, 4'd14, 4'd13, 4'd12};
`else
      exps = '{4'd15, 4'd0, 4'd0, 4'd0};
`endif
      do_reset();
      for (int k = 0; k < 4; k++) begin
         run_window((k == 0) ? 12'd4095 : 12'd2048, 0, 0);
         checks++; if (lvl_end !== exps[k]) begin errors++; $display("FAIL t6_level[%0d] got %0d exp %0d", k, lvl_end, exps[k]); end
         checks++; if (pk_end !== ((k == 0) ? 12'd4095 : 12'd2048)) begin errors++; $display("FAIL t6_peak[%0d] got %0d", k, pk_end); end
      end
   endtask

   initial begin
      test_reset();
      test_quantise();
      test_last_sample();
      test_back_to_back();
      test_freeze();
      test_decay();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
